// File: rtl/mem_if_arbiter_pkg.sv
// Shared types for the instruction/data MEM arbiter and its response tag FIFO.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
  typedef enum logic {ID_INSTR = 1'b0, ID_DATA = 1'b1} arb_id_t;

  function automatic arb_id_t other_id(input arb_id_t id);
    return (id == ID_INSTR) ? ID_DATA : ID_INSTR;
  endfunction

endpackage

// File: rtl/mem_if_arbiter_tag_fifo.sv
// Tag FIFO holding the requester ID of every granted transaction until its
// in-order response returns. Push is refused when full, pop when empty.
module mem_arb_tag_fifo #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == {CntW{1'b0}});
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rptr_q];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= {Depth{1'b0}};
      wptr_q <= {PtrW{1'b0}};
      rptr_q <= {PtrW{1'b0}};
      cnt_q  <= {CntW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_ok_s) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_if_arbiter.sv
// Two-to-one MEM arbiter (instr/data -> one master port) with in-order response
// steering. Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is data-first priority.
module mem_if_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_mem_req,
  output logic                   instr_mem_gnt,
  output logic                   instr_mem_valid,
  input  logic [AddrWidth-1:0]   instr_mem_addr,
  input  logic [DataWidth-1:0]   instr_mem_wdata,
  input  logic                   instr_mem_we,
  input  logic [DataWidth/8-1:0] instr_mem_be,
  output logic [DataWidth-1:0]   instr_mem_rdata,
  input  logic                   data_mem_req,
  output logic                   data_mem_gnt,
  output logic                   data_mem_valid,
  input  logic [AddrWidth-1:0]   data_mem_addr,
  input  logic [DataWidth-1:0]   data_mem_wdata,
  input  logic                   data_mem_we,
  input  logic [DataWidth/8-1:0] data_mem_be,
  output logic [DataWidth-1:0]   data_mem_rdata,
  output logic                   m_mem_req,
  output logic [AddrWidth-1:0]   m_mem_addr,
  output logic [DataWidth-1:0]   m_mem_wdata,
  output logic                   m_mem_we,
  output logic [DataWidth/8-1:0] m_mem_be,
  input  logic                   m_mem_gnt,
  input  logic                   m_mem_valid,
  input  logic [DataWidth-1:0]   m_mem_rdata,
  output logic                   resp_err_o
);

  arb_state_t state_q, state_d;
  arb_id_t    lock_id_q, lock_id_d;
  arb_id_t    pick_s, cur_id_s;
  logic       req_s, gnt_s, pop_s;
  logic       fifo_full_s, fifo_empty_s, fifo_head_s;
  logic       resp_err_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_id_t rr_q;

  // Simultaneous requests go to the port not granted most recently.
  always_comb begin
    if (instr_mem_req && data_mem_req) begin
      pick_s = rr_q;
    end else if (data_mem_req) begin
      pick_s = ID_DATA;
    end else begin
      pick_s = ID_INSTR;
    end
  end

  // Round-robin pointer: after each grant the other port is preferred.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= ID_INSTR;
    end else if (gnt_s) begin
      rr_q <= other_id(cur_id_s);
    end
  end
`else
  // Fixed priority, data ahead of instr.
  always_comb begin
    if (data_mem_req) begin
      pick_s = ID_DATA;
    end else begin
      pick_s = ID_INSTR;
    end
  end
`endif

  // Next-state logic; a stalled winner keeps the master port until granted.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    cur_id_s  = pick_s;
    req_s     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        cur_id_s = pick_s;
        req_s    = (instr_mem_req | data_mem_req) & ~fifo_full_s;
        if (req_s && !m_mem_gnt) begin
          state_d   = ARB_LOCKED;
          lock_id_d = pick_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        cur_id_s = lock_id_q;
        req_s    = ((lock_id_q == ID_DATA) ? data_mem_req : instr_mem_req) & ~fifo_full_s;
        // A winner dropping its request is a protocol violation: abandon the lock.
        if (!req_s || m_mem_gnt) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM state, locked winner and the unexpected-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_id_q  <= ID_INSTR;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      resp_err_q <= m_mem_valid & fifo_empty_s;
    end
  end

  assign gnt_s = m_mem_gnt & req_s;
  assign pop_s = m_mem_valid & ~fifo_empty_s;

  mem_arb_tag_fifo #(
    .Depth (MaxOutstanding)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (gnt_s),
    .push_data_i (cur_id_s == ID_DATA),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (fifo_head_s)
  );

  assign m_mem_req   = req_s;
  assign m_mem_addr  = !req_s ? '0 : (cur_id_s == ID_DATA) ? data_mem_addr  : instr_mem_addr;
  assign m_mem_wdata = !req_s ? '0 : (cur_id_s == ID_DATA) ? data_mem_wdata : instr_mem_wdata;
  assign m_mem_we    = req_s & ((cur_id_s == ID_DATA) ? data_mem_we : instr_mem_we);
  assign m_mem_be    = !req_s ? '0 : (cur_id_s == ID_DATA) ? data_mem_be    : instr_mem_be;

  assign instr_mem_gnt   = gnt_s & (cur_id_s == ID_INSTR);
  assign data_mem_gnt    = gnt_s & (cur_id_s == ID_DATA);
  assign instr_mem_valid = pop_s & ~fifo_head_s;
  assign data_mem_valid  = pop_s & fifo_head_s;
  assign instr_mem_rdata = instr_mem_valid ? m_mem_rdata : '0;
  assign data_mem_rdata  = data_mem_valid  ? m_mem_rdata : '0;
  assign resp_err_o      = resp_err_q;

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed table-driven bench for mem_if_arbiter (depth-2 main instance, depth-4 instance
// for the interleaved-response sequence).
module tb_mem_if_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [31:0] IADDR  = 32'h0000_0080;
  localparam logic [31:0] DADDR  = 32'h0000_1000;
  localparam logic [31:0] IWDATA = 32'h1234_5678;
  localparam logic [31:0] DWDATA = 32'hCAFE_0000;
  localparam logic [3:0]  IBE    = 4'hF;
  localparam logic [3:0]  DBE    = 4'h3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic ireq = 1'b0, dreq = 1'b0, mgnt = 1'b0, mvalid = 1'b0;
  logic [31:0] mrdata = 32'h0;

  logic igant, ivalid, dgnt, dvalid, mreq, mwe, rerr;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0] mbe;
  logic igant4, ivalid4, dgnt4, dvalid4, mreq4, mwe4, rerr4;
  logic [31:0] irdata4, drdata4, maddr4, mwdata4;
  logic [3:0] mbe4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_if_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_mem_req(ireq), .instr_mem_gnt(igant), .instr_mem_valid(ivalid),
    .instr_mem_addr(IADDR), .instr_mem_wdata(IWDATA), .instr_mem_we(1'b0),
    .instr_mem_be(IBE), .instr_mem_rdata(irdata),
    .data_mem_req(dreq), .data_mem_gnt(dgnt), .data_mem_valid(dvalid),
    .data_mem_addr(DADDR), .data_mem_wdata(DWDATA), .data_mem_we(1'b1),
    .data_mem_be(DBE), .data_mem_rdata(drdata),
    .m_mem_req(mreq), .m_mem_addr(maddr), .m_mem_wdata(mwdata), .m_mem_we(mwe),
    .m_mem_be(mbe), .m_mem_gnt(mgnt), .m_mem_valid(mvalid), .m_mem_rdata(mrdata),
    .resp_err_o(rerr)
  );

  mem_if_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_mem_req(ireq), .instr_mem_gnt(igant4), .instr_mem_valid(ivalid4),
    .instr_mem_addr(IADDR), .instr_mem_wdata(IWDATA), .instr_mem_we(1'b0),
    .instr_mem_be(IBE), .instr_mem_rdata(irdata4),
    .data_mem_req(dreq), .data_mem_gnt(dgnt4), .data_mem_valid(dvalid4),
    .data_mem_addr(DADDR), .data_mem_wdata(DWDATA), .data_mem_we(1'b1),
    .data_mem_be(DBE), .data_mem_rdata(drdata4),
    .m_mem_req(mreq4), .m_mem_addr(maddr4), .m_mem_wdata(mwdata4), .m_mem_we(mwe4),
    .m_mem_be(mbe4), .m_mem_gnt(mgnt), .m_mem_valid(mvalid), .m_mem_rdata(mrdata),
    .resp_err_o(rerr4)
  );

  // One cycle of stimulus: ir/dr/g/vl/rd drive; mr..er are expected outputs.
  // w is the expected winner on the master port (0 instr, 1 data).
  typedef struct {
    bit ir, dr, g, vl;
    logic [31:0] rd;
    bit mr, w, ig, dg, iv, dv, er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit ir, bit dr, bit g, bit vl, logic [31:0] rd,
                             bit mr, bit w, bit ig, bit dg, bit iv, bit dv, bit er);
    vec_t t;
    t.ir = ir; t.dr = dr; t.g = g; t.vl = vl; t.rd = rd;
    t.mr = mr; t.w = w; t.ig = ig; t.dg = dg; t.iv = iv; t.dv = dv; t.er = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit ir, input bit dr, input bit g, input bit vl, input logic [31:0] rd);
    ireq = ir; dreq = dr; mgnt = g; mvalid = vl; mrdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit wa, wb, wc;
    wa = ~RR; wb = 1'b1; wc = ~RR;

    // Post-reset idle
    vecs.push_back(v(0,0,0,0,32'h0,        0,0, 0,0,0,0,0));
    // Both request every cycle with same-cycle grants; responses trail by one
    vecs.push_back(v(1,1,1,0,32'h0,        1,wa, !wa,wa, 0,0,0));
    vecs.push_back(v(1,1,1,1,32'hA,        1,wb, !wb,wb, !wa,wa,0));
    vecs.push_back(v(1,1,1,1,32'hB,        1,wc, !wc,wc, !wb,wb,0));
    vecs.push_back(v(0,0,0,1,32'hC,        0,0, 0,0, !wc,wc,0));
    vecs.push_back(v(1,0,1,0,32'h0,        1,0, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'hD,        0,0, 0,0,1,0,0));
    // Instr read at 0x80, response two cycles later
    vecs.push_back(v(1,0,1,0,32'h0,        1,0, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,32'h0,        0,0, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'hDEADBEEF, 0,0, 0,0,1,0,0));
    // Data stalled 3 cycles, instr arrives mid-stall
    vecs.push_back(v(0,1,0,0,32'h0,        1,1, 0,0,0,0,0));
    vecs.push_back(v(1,1,0,0,32'h0,        1,1, 0,0,0,0,0));
    vecs.push_back(v(1,1,0,0,32'h0,        1,1, 0,0,0,0,0));
    vecs.push_back(v(1,1,1,0,32'h0,        1,1, 0,1,0,0,0));
    // Instr stalled, data arrives mid-stall (data would win unlocked)
    vecs.push_back(v(1,0,0,1,32'h5,        1,0, 0,0,0,1,0));
    vecs.push_back(v(1,1,0,0,32'h0,        1,0, 0,0,0,0,0));
    vecs.push_back(v(1,1,1,0,32'h0,        1,0, 1,0,0,0,0));
    vecs.push_back(v(0,1,1,1,32'h6,        1,1, 0,1,1,0,0));
    vecs.push_back(v(0,0,0,1,32'h7,        0,0, 0,0,0,1,0));
    // Locked winner drops its request
    vecs.push_back(v(1,0,0,0,32'h0,        1,0, 0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,32'h0,        0,0, 0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,32'h0,        1,1, 0,1,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h8,        0,0, 0,0,0,1,0));
    // Depth-2 FIFO fills; pop in the full cycle does not allow a grant
    vecs.push_back(v(1,0,1,0,32'h0,        1,0, 1,0,0,0,0));
    vecs.push_back(v(0,1,1,0,32'h0,        1,1, 0,1,0,0,0));
    vecs.push_back(v(1,0,1,0,32'h0,        0,0, 0,0,0,0,0));
    vecs.push_back(v(1,0,1,1,32'h9,        0,0, 0,0,1,0,0));
    vecs.push_back(v(1,0,1,0,32'h0,        1,0, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'hA,        0,0, 0,0,0,1,0));
    vecs.push_back(v(0,0,0,1,32'hB,        0,0, 0,0,1,0,0));
    // Response with empty FIFO: dropped, error one cycle later for one cycle
    vecs.push_back(v(0,0,0,1,32'hE,        0,0, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,32'h0,        0,0, 0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,32'h0,        0,0, 0,0,0,0,0));

    // Reset state
    @(posedge clk);
    #4;
    chk("rst m_req", {31'd0, mreq}, 32'd0);
    chk("rst m_addr", maddr, 32'd0);
    chk("rst gnt", {30'd0, igant, dgnt}, 32'd0);
    chk("rst valid", {30'd0, ivalid, dvalid}, 32'd0);
    chk("rst resp_err", {31'd0, rerr}, 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].dr, vecs[i].g, vecs[i].vl, vecs[i].rd);
      #4;
      chk($sformatf("v%0d m_req", i), {31'd0, mreq}, {31'd0, vecs[i].mr});
      chk($sformatf("v%0d m_addr", i), maddr, vecs[i].mr ? (vecs[i].w ? DADDR : IADDR) : 32'd0);
      chk($sformatf("v%0d m_wdata", i), mwdata, vecs[i].mr ? (vecs[i].w ? DWDATA : IWDATA) : 32'd0);
      chk($sformatf("v%0d m_we", i), {31'd0, mwe}, {31'd0, vecs[i].mr & vecs[i].w});
      chk($sformatf("v%0d m_be", i), {28'd0, mbe}, {28'd0, vecs[i].mr ? (vecs[i].w ? DBE : IBE) : 4'h0});
      chk($sformatf("v%0d instr_gnt", i), {31'd0, igant}, {31'd0, vecs[i].ig});
      chk($sformatf("v%0d data_gnt", i), {31'd0, dgnt}, {31'd0, vecs[i].dg});
      chk($sformatf("v%0d instr_valid", i), {31'd0, ivalid}, {31'd0, vecs[i].iv});
      chk($sformatf("v%0d data_valid", i), {31'd0, dvalid}, {31'd0, vecs[i].dv});
      chk($sformatf("v%0d instr_rdata", i), irdata, vecs[i].iv ? vecs[i].rd : 32'd0);
      chk($sformatf("v%0d data_rdata", i), drdata, vecs[i].dv ? vecs[i].rd : 32'd0);
      chk($sformatf("v%0d resp_err", i), {31'd0, rerr}, {31'd0, vecs[i].er});
      next_cycle();
    end

    // Reset asserted with one tag outstanding; later response is unexpected
    drive(1, 0, 1, 0, 32'h0);
    #4;
    chk("mid instr_gnt", {31'd0, igant}, 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 32'h0);
    rst_ni = 1'b0;
    #4;
    chk("mid rst outputs", {26'd0, mreq, igant, dgnt, ivalid, dvalid, rerr}, 32'd0);
    next_cycle();
    rst_ni = 1'b1;
    drive(0, 0, 0, 1, 32'h77);
    #4;
    chk("post-rst valid", {30'd0, ivalid, dvalid}, 32'd0);
    chk("post-rst rdata", irdata | drdata, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 32'h0);
    #4;
    chk("post-rst resp_err", {31'd0, rerr}, 32'd1);
    next_cycle();
    #4;
    chk("post-rst resp_err clr", {31'd0, rerr}, 32'd0);
    next_cycle();

    // Depth-4 instance: grants instr,data,instr then responses 1,2,3 in order
    drive(1, 0, 1, 0, 32'h0);
    #4;
    chk("d4 g0 instr_gnt", {31'd0, igant4}, 32'd1);
    next_cycle();
    drive(0, 1, 1, 0, 32'h0);
    #4;
    chk("d4 g1 data_gnt", {31'd0, dgnt4}, 32'd1);
    next_cycle();
    drive(1, 0, 1, 0, 32'h0);
    #4;
    chk("d4 g2 m_req", {31'd0, mreq4}, 32'd1);
    chk("d4 g2 instr_gnt", {31'd0, igant4}, 32'd1);
    chk("d2 full m_req", {31'd0, mreq}, 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 32'(k + 1));
      #4;
      chk($sformatf("d4 r%0d instr_valid", k), {31'd0, ivalid4}, {31'd0, k != 1});
      chk($sformatf("d4 r%0d data_valid", k), {31'd0, dvalid4}, {31'd0, k == 1});
      chk($sformatf("d4 r%0d rdata", k), (k == 1) ? drdata4 : irdata4, 32'(k + 1));
      next_cycle();
    end
    drive(0, 0, 0, 0, 32'h0);
    #4;
    chk("d4 resp_err", {31'd0, rerr4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
